// File: rtl/pll_reset_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_QUALIFY   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_RESET_HOLD_CYCLES  = 16;
    localparam int DEF_STAGES             = 3;
    localparam int DEF_STAGE_GAP_CYCLES   = 4;
    localparam int DEF_LOSS_CNT_WIDTH     = 8;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop single-bit synchroniser with synchronous reset to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release driven by a qualified PLL lock indication.
// Optional lock-loss event counter: define PLL_LOCK_LOSS_CNT_EN to build it,
// otherwise lock_loss_count is tied to 0.
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int STAGES             = DEF_STAGES,
    parameter int STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
    parameter int LOSS_CNT_WIDTH     = DEF_LOSS_CNT_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      locked_in,
    input  logic                      user_reset_req,
    output logic [STAGES-1:0]         reset_out,
    output logic                      ready,
    output logic [2:0]                state_o,
    output logic [LOSS_CNT_WIDTH-1:0] lock_loss_count
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $fatal(1, "SYNC_STAGES out of range");
    end
    if (LOCK_STABLE_CYCLES < 1 || RESET_HOLD_CYCLES < 1 || STAGE_GAP_CYCLES < 1) begin : g_bad_cyc
        $fatal(1, "cycle parameters must be >= 1");
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $fatal(1, "STAGES out of range");
    end
    if (LOSS_CNT_WIDTH < 1) begin : g_bad_loss
        $fatal(1, "LOSS_CNT_WIDTH must be >= 1");
    end

    localparam int SCW  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int HCW  = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int GCW  = $clog2(STAGE_GAP_CYCLES + 1);
    localparam int IDXW = $clog2(STAGES + 1);

    localparam logic [SCW-1:0]  STABLE_LAST = SCW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HCW-1:0]  HOLD_LAST   = HCW'(RESET_HOLD_CYCLES - 1);
    localparam logic [GCW-1:0]  GAP_LAST    = GCW'(STAGE_GAP_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST    = IDXW'(STAGES - 1);

    logic locked_s;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (locked_in),
        .q_o   (locked_s)
    );

    state_t            state_q, state_d;
    logic [SCW-1:0]    stable_q, stable_d;
    logic [HCW-1:0]    hold_q, hold_d;
    logic [GCW-1:0]    gap_q, gap_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [STAGES-1:0] reset_out_q, reset_out_d;
    logic              ready_q, ready_d;
    logic              loss_evt;

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_WAIT_LOCK;
            stable_q <= '0;
            hold_q   <= '0;
            gap_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state logic; counters default to 0 so every state entry starts clean
    always_comb begin
        state_d  = state_q;
        stable_d = '0;
        hold_d   = '0;
        gap_d    = '0;
        idx_d    = '0;
        loss_evt = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) state_d = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                // a drop here is still qualification noise, not a lock loss
                if (!locked_s)                  state_d = ST_WAIT_LOCK;
                else if (stable_q == STABLE_LAST) state_d = ST_HOLD;
                else                            stable_d = stable_q + SCW'(1);
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    loss_evt = 1'b1;
                end else if (user_reset_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            ST_RELEASE: begin
                idx_d = idx_q;
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    loss_evt = 1'b1;
                    idx_d    = '0;
                end else if (user_reset_req) begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                end else if (idx_q == IDX_LAST) begin
                    // only reachable with a single stage: RELEASE lasts one cycle
                    state_d = ST_RUN;
                end else if (gap_q == GAP_LAST) begin
                    idx_d = idx_q + IDXW'(1);
                    if (idx_d == IDX_LAST) state_d = ST_RUN;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    loss_evt = 1'b1;
                end else if (user_reset_req) begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    // Output decode from the upcoming state so the outputs leave a flop
    always_comb begin
        reset_out_d = '1;
        ready_d     = 1'b0;
        case (state_d)
            ST_RELEASE: begin
                for (int i = 0; i < STAGES; i++)
                    if (IDXW'(i) <= idx_d) reset_out_d[i] = 1'b0;
            end
            ST_RUN: begin
                reset_out_d = '0;
                ready_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs keep the resets glitch-free
    always_ff @(posedge clock) begin
        if (reset) begin
            reset_out_q <= '1;
            ready_q     <= 1'b0;
        end else begin
            reset_out_q <= reset_out_d;
            ready_q     <= ready_d;
        end
    end

    assign reset_out = reset_out_q;
    assign ready     = ready_q;
    assign state_o   = state_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt_q;

    // Saturating lock-loss event counter
    always_ff @(posedge clock) begin
        if (reset)                           loss_cnt_q <= '0;
        else if (loss_evt && loss_cnt_q != '1) loss_cnt_q <= loss_cnt_q + LOSS_CNT_WIDTH'(1);
    end

    assign lock_loss_count = loss_cnt_q;
`else
    logic unused_loss_evt;
    assign unused_loss_evt = loss_evt;
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a small configuration
// (sync 2, qualify 8, hold 4, 3 stages, gap 2, 2-bit loss counter).
module tb_pll_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       locked_in;
    logic       user_reset_req;
    logic [2:0] reset_out;
    logic       ready;
    logic [2:0] state_o;
    logic [1:0] lock_loss_count;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_e  = 0;
    int losses = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .STAGES             (3),
        .STAGE_GAP_CYCLES   (2),
        .LOSS_CNT_WIDTH     (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .locked_in       (locked_in),
        .user_reset_req  (user_reset_req),
        .reset_out       (reset_out),
        .ready           (ready),
        .state_o         (state_o),
        .lock_loss_count (lock_loss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (edge %0d): observed=%0h expected=%0h", tag, cur_e, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef PLL_LOCK_LOSS_CNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    // Full lock-to-run sequence; edge 1 is the first edge sampling locked_in=1
    task automatic run_seq(input int start);
        for (int e = start; e <= 19; e++) begin
            step();
            cur_e = e;
            chk("seq_state", 32'(state_o),
                (e < 3) ? 0 : (e < 11) ? 1 : (e < 15) ? 2 : (e < 19) ? 3 : 4);
            chk("seq_rst", 32'(reset_out),
                (e < 15) ? 7 : (e < 17) ? 6 : (e < 19) ? 4 : 0);
            chk("seq_ready", 32'(ready), (e >= 19) ? 1 : 0);
        end
        chk("seq_cnt", 32'(lock_loss_count), 32'(exp_cnt(losses)));
    endtask

    // Drop lock for 3 cycles from RUN; optionally collide a user request
    task automatic lose_lock(input bit with_req);
        locked_in = 1'b0;
        step(); cur_e = 1;
        chk("loss_still_run", 32'(state_o), 4);
        step(); cur_e = 2;
        chk("loss_still_rdy", 32'(ready), 1);
        if (with_req) user_reset_req = 1'b1;
        step(); cur_e = 3;
        user_reset_req = 1'b0;
        losses++;
        chk("loss_state", 32'(state_o), 0);
        chk("loss_rst", 32'(reset_out), 7);
        chk("loss_ready", 32'(ready), 0);
        chk("loss_cnt", 32'(lock_loss_count), 32'(exp_cnt(losses)));
        locked_in = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        locked_in      = 1'b0;
        user_reset_req = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_rst", 32'(reset_out), 7);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_cnt", 32'(lock_loss_count), 0);
        reset = 1'b0;
        step();
        step();
        chk("idle_state", 32'(state_o), 0);

        // clean lock
        locked_in = 1'b1;
        run_seq(1);

        // lock loss from RUN, then relock
        lose_lock(1'b0);
        run_seq(1);

        // user reset request from RUN
        user_reset_req = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            user_reset_req = 1'b0;
            cur_e = e;
            chk("ureq_state", 32'(state_o), (e < 5) ? 2 : (e < 9) ? 3 : 4);
            chk("ureq_rst", 32'(reset_out), (e < 5) ? 7 : (e < 7) ? 6 : (e < 9) ? 4 : 0);
            chk("ureq_ready", 32'(ready), (e >= 9) ? 1 : 0);
        end
        chk("ureq_cnt", 32'(lock_loss_count), 32'(exp_cnt(losses)));

        // saturation: four more losses, the first colliding with a request
        for (int k = 0; k < 4; k++) begin
            lose_lock(k == 0);
            run_seq(1);
        end

        // reset during RELEASE with lock held
        lose_lock(1'b0);
        for (int e = 1; e <= 16; e++) step();
        cur_e = 16;
        chk("mid_state", 32'(state_o), 3);
        chk("mid_rst", 32'(reset_out), 6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        losses = 0;
        chk("mrst_state", 32'(state_o), 0);
        chk("mrst_rst", 32'(reset_out), 7);
        chk("mrst_ready", 32'(ready), 0);
        chk("mrst_cnt", 32'(lock_loss_count), 0);
        run_seq(1);

        // qualification glitch: high 5, low 1, high again
        reset     = 1'b1;
        locked_in = 1'b0;
        step();
        reset = 1'b0;
        step();
        locked_in = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        locked_in = 1'b0;
        step();
        cur_e = 6;
        chk("glitch_q", 32'(state_o), 1);
        locked_in = 1'b1;
        step();
        cur_e = 7;
        chk("glitch_q2", 32'(state_o), 1);
        step();
        cur_e = 8;
        chk("glitch_wait", 32'(state_o), 0);
        chk("glitch_rst", 32'(reset_out), 7);
        chk("glitch_cnt", 32'(lock_loss_count), 0);
        run_seq(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
